edge_driver_full: RTL and testbench
===================================

// Module: edge_driver_full
//
// PURPOSE
// - Transmit-side counterpart of the edge-sensing monostables: turns edge requests into a clean output line.
// - Accepts rise/fall/toggle ops over valid/ready; each real edge is followed by a programmable minimum hold.
// - Emits one-tick edge strobes aligned to the line change, matching what an edge detector on line_o would report.
// - Sits in common_global; drives strobes, gate controls and handshake lines consumed by monostable_full on the far end.
//
// PARAMETERS
// - HOLD_W       8     width of min_high_i / min_low_i and of the hold counter.
// - RESET_LEVEL  1'b0  line_o value during and after reset.
//
// PORTS
// - clk_dom_i        in   struct  common_p::clk_dom_s; clk used, clk_en qualifies every state update; sync_rst field ignored.
// - async_rst_i      in   1       asynchronous active-high reset.
// - drive_en_i       in   1       0: no requests accepted; line_o held; running hold still counts.
// - req_valid_i      in   1       request present.
// - req_op_i         in   2       01 rise, 10 fall, 11 toggle, 00 no-op.
// - req_ready_o      out  1       request can be accepted this tick.
// - min_high_i       in   HOLD_W  min ticks line_o stays high after a rising edge; sampled at acceptance.
// - min_low_i        in   HOLD_W  min ticks line_o stays low after a falling edge; sampled at acceptance.
// - line_o           out  1       registered output line.
// - posedge_mono_o   out  1       one-tick strobe, high in the first tick line_o is newly 1.
// - negedge_mono_o   out  1       one-tick strobe, high in the first tick line_o is newly 0.
// - redundant_mono_o out  1       one-tick strobe: accepted op produced no edge.
// - busy_o           out  1       hold counter non-zero.
//
// BEHAVIOUR
// - Tick = rising clk with clk_en=1. All registers update only on ticks; with clk_en=0 everything is frozen.
// - Reset (async, active-high): line_o=RESET_LEVEL; all strobes, busy_o and hold counter 0; state IDLE.
// - States: IDLE (cnt==0) and HOLD (cnt!=0).
// - req_ready_o = drive_en_i && IDLE && ~async_rst_i (combinational).
// - Transfer = tick && req_valid_i && req_ready_o. Upstream keeps req_op_i stable until the transfer.
// - Target level: rise->1, fall->0, toggle->~line_o, no-op->line_o.
// - Target != line_o at transfer tick t:
//   - line_o flips at t (visible from t+1), with the matching edge strobe.
//   - cnt loads min_high_i (rising) or min_low_i (falling).
// - Target == line_o: no edge; redundant_mono_o at t; cnt stays 0; ready stays high.
// - HOLD: cnt decrements each tick; ready low. Hold N gives ready low for N ticks, high again at t+N+1.
// - N=0: no HOLD; back-to-back edges every tick are legal (toggle each tick gives line_o = clk_en-rate square wave).
// - Strobes are registered and cleared on the next tick; with clk_en low they hold their value.
// - posedge/negedge/redundant strobes are mutually exclusive; busy_o == (cnt!=0).
// - drive_en_i low mid-HOLD: counting continues to 0; ready stays low until drive_en_i returns high.
// - Reset mid-HOLD: hold aborted, line_o forced to RESET_LEVEL with no edge strobe.
// - Widths: cnt is HOLD_W bits, loaded directly, never wraps (decrement only while non-zero).
//
// CONFIGURATION
// - EDGE_DRIVER_FULL_STATS_EN defined:
//   - adds output edge_count_o [15:0], counting real edges; +1 per edge strobe; wraps 16'hFFFF->0.
//   - reset to 0.
// - Not defined: port and counter absent; all other behaviour identical.
//
// TESTING
// - Reset, RESET_LEVEL=0, drive_en=1 -> line_o=0, ready=1, busy=0, all strobes 0.
// - Rise, min_high=3, at tick t -> line_o=1 and posedge_mono_o=1 at t+1; ready low t+1..t+3, high t+4.
// - Fall while line_o=0 -> redundant_mono_o=1 one tick; line_o stays 0; ready never drops.
// - min_high=min_low=0, toggle held valid 6 ticks -> line_o alternates every tick; 6 strobes.
// - clk_en low 5 clks mid-hold -> cnt, line_o, strobes frozen; hold resumes with the same remaining count.
// - async_rst_i pulse mid-hold (line_o=1) -> line_o=0 immediately, busy=0, no negedge strobe.
// - STATS_EN: 65537 toggles -> edge_count_o==1.

Source files
------------

// File: rtl/edge_driver_full.sv
// edge_driver_full
// Turns rise/fall/toggle requests into a registered output line.
// After every real edge, a programmable minimum hold keeps the line stable.
// One-tick strobes report each edge, and also each accepted request that caused no edge.
// Optional feature: define EDGE_DRIVER_FULL_STATS_EN to add edge_count_o,
// a 16-bit wrapping count of real edges.

package common_p;
  typedef struct packed {
    logic clk;
    logic clk_en;
    logic sync_rst;
  } clk_dom_s;
endpackage

module edge_driver_full #(
  parameter int   HOLD_W      = 8,
  parameter logic RESET_LEVEL = 1'b0
) (
  input  common_p::clk_dom_s clk_dom_i,
  input  logic               async_rst_i,
  input  logic               drive_en_i,
  input  logic               req_valid_i,
  input  logic [1:0]         req_op_i,
  output logic               req_ready_o,
  input  logic [HOLD_W-1:0]  min_high_i,
  input  logic [HOLD_W-1:0]  min_low_i,
  output logic               line_o,
  output logic               posedge_mono_o,
  output logic               negedge_mono_o,
  output logic               redundant_mono_o,
  output logic               busy_o
`ifdef EDGE_DRIVER_FULL_STATS_EN
  ,
  output logic [15:0]        edge_count_o
`endif
);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_e;

  localparam logic [1:0] OP_RISE   = 2'b01;
  localparam logic [1:0] OP_FALL   = 2'b10;
  localparam logic [1:0] OP_TOGGLE = 2'b11;

  logic clk;
  logic clk_en;
  logic unused_sync_rst;

  assign clk             = clk_dom_i.clk;
  assign clk_en          = clk_dom_i.clk_en;
  assign unused_sync_rst = clk_dom_i.sync_rst;

  logic              line_reg, line_next;
  logic [HOLD_W-1:0] cnt_reg, cnt_next;
  logic              pos_reg, pos_next;
  logic              neg_reg, neg_next;
  logic              red_reg, red_next;

  state_e state;
  logic   ready;
  logic   xfer;
  logic   target;

  // The state is fully described by the hold counter: a non-zero count means HOLD.
  assign state = (cnt_reg == '0) ? IDLE : HOLD;

  // State register. Everything freezes when clk_en is low, strobes included.
  always_ff @(posedge clk or posedge async_rst_i) begin
    if (async_rst_i) begin
      line_reg <= RESET_LEVEL;
      cnt_reg  <= '0;
      pos_reg  <= 1'b0;
      neg_reg  <= 1'b0;
      red_reg  <= 1'b0;
    end else if (clk_en) begin
      line_reg <= line_next;
      cnt_reg  <= cnt_next;
      pos_reg  <= pos_next;
      neg_reg  <= neg_next;
      red_reg  <= red_next;
    end
  end

  // Next state: count down any running hold, then apply an accepted request.
  // A request is accepted only in IDLE, so loading the counter never clashes
  // with the decrement.
  always_comb begin
    line_next = line_reg;
    cnt_next  = cnt_reg;
    pos_next  = 1'b0;
    neg_next  = 1'b0;
    red_next  = 1'b0;
    target    = line_reg;
    xfer      = req_valid_i && ready;

    if (state == HOLD) begin
      cnt_next = cnt_reg - 1'b1;
    end

    if (xfer) begin
      case (req_op_i)
        OP_RISE:   target = 1'b1;
        OP_FALL:   target = 1'b0;
        OP_TOGGLE: target = ~line_reg;
        default:   target = line_reg;
      endcase

      if (target != line_reg) begin
        line_next = target;
        cnt_next  = target ? min_high_i : min_low_i;
        pos_next  = target;
        neg_next  = ~target;
      end else begin
        red_next  = 1'b1;
      end
    end
  end

  // Outputs. Ready is combinational so that a zero-length hold allows an edge on every tick.
  always_comb begin
    ready = drive_en_i && (state == IDLE) && !async_rst_i;
  end

  assign req_ready_o      = ready;
  assign line_o           = line_reg;
  assign posedge_mono_o   = pos_reg;
  assign negedge_mono_o   = neg_reg;
  assign redundant_mono_o = red_reg;
  assign busy_o           = (state == HOLD);

`ifdef EDGE_DRIVER_FULL_STATS_EN
  logic [15:0] edge_count_reg;

  // Edge statistics: counts each real edge in the same tick its strobe is registered, and wraps.
  always_ff @(posedge clk or posedge async_rst_i) begin
    if (async_rst_i) begin
      edge_count_reg <= 16'd0;
    end else if (clk_en && (pos_next || neg_next)) begin
      edge_count_reg <= edge_count_reg + 16'd1;
    end
  end

  assign edge_count_o = edge_count_reg;
`endif

endmodule

// File: tb/tb_edge_driver_full.sv
// tb_edge_driver_full
// Drives randomized and directed requests into edge_driver_full.
// Each tick, the outputs are compared with a tick-indexed reference model.
// With EDGE_DRIVER_FULL_STATS_EN defined, the edge counter and its wrap are also checked.

module tb_edge_driver_full;

  logic       clk = 1'b0;
  logic       clk_en = 1'b1;
  logic       rst = 1'b1;
  logic       drive_en = 1'b0;
  logic       req_valid = 1'b0;
  logic [1:0] req_op = 2'b00;
  logic [7:0] min_high = 8'd0;
  logic [7:0] min_low = 8'd0;
  logic       req_ready;
  logic       line;
  logic       pos_mono;
  logic       neg_mono;
  logic       red_mono;
  logic       busy;
  common_p::clk_dom_s clk_dom;

  assign clk_dom = {clk, clk_en, 1'b0};

`ifdef EDGE_DRIVER_FULL_STATS_EN
  logic [15:0] edge_count;
`endif

  edge_driver_full #(
    .HOLD_W      (8),
    .RESET_LEVEL (1'b0)
  ) dut (
    .clk_dom_i        (clk_dom),
    .async_rst_i      (rst),
    .drive_en_i       (drive_en),
    .req_valid_i      (req_valid),
    .req_op_i         (req_op),
    .req_ready_o      (req_ready),
    .min_high_i       (min_high),
    .min_low_i        (min_low),
    .line_o           (line),
    .posedge_mono_o   (pos_mono),
    .negedge_mono_o   (neg_mono),
    .redundant_mono_o (red_mono),
    .busy_o           (busy)
`ifdef EDGE_DRIVER_FULL_STATS_EN
    ,
    .edge_count_o     (edge_count)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Reference model. m_tick counts enabled ticks; the line is busy until m_tick reaches m_hold_end.
  logic m_line;
  int   m_tick;
  int   m_hold_end;
  logic m_pos, m_neg, m_red;
  int   m_edges;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_line     = 1'b0;
    m_tick     = 0;
    m_hold_end = 0;
    m_pos      = 1'b0;
    m_neg      = 1'b0;
    m_red      = 1'b0;
    m_edges    = 0;
  endfunction

  function automatic logic model_ready(input logic den);
    return den && (m_tick >= m_hold_end);
  endfunction

  function automatic void model_tick(input logic xfer, input logic [1:0] op,
                                     input logic [7:0] mh, input logic [7:0] ml);
    logic tgt;
    m_pos = 1'b0;
    m_neg = 1'b0;
    m_red = 1'b0;
    if (xfer) begin
      tgt = (op == 2'b01) ? 1'b1 :
            (op == 2'b10) ? 1'b0 :
            (op == 2'b11) ? ~m_line : m_line;
      if (tgt != m_line) begin
        m_line     = tgt;
        m_pos      = tgt;
        m_neg      = ~tgt;
        m_hold_end = m_tick + 1 + int'(tgt ? mh : ml);
        m_edges++;
      end else begin
        m_red = 1'b1;
      end
    end
    m_tick++;
  endfunction

  // One clock: apply inputs at the negedge, check ready, advance, then check registered outputs.
  task automatic step(input logic en, input logic den, input logic vld, input logic [1:0] op,
                      input logic [7:0] mh, input logic [7:0] ml);
    logic exp_ready;
    clk_en    = en;
    drive_en  = den;
    req_valid = vld;
    req_op    = op;
    min_high  = mh;
    min_low   = ml;
    #1;
    exp_ready = model_ready(den);
    check("ready", 32'(req_ready), 32'(exp_ready));
    @(posedge clk);
    if (en) model_tick(vld && exp_ready, op, mh, ml);
    @(negedge clk);
    check("line", 32'(line), 32'(m_line));
    check("pos", 32'(pos_mono), 32'(m_pos));
    check("neg", 32'(neg_mono), 32'(m_neg));
    check("red", 32'(red_mono), 32'(m_red));
    check("busy", 32'(busy), 32'(m_tick < m_hold_end));
`ifdef EDGE_DRIVER_FULL_STATS_EN
    check("edges", 32'(edge_count), 32'(m_edges % 65536));
`endif
  endtask

  // Pulse the asynchronous reset between clock edges; the outputs must clear at once.
  task automatic reset_pulse();
    #2;
    rst = 1'b1;
    #1;
    check("rst_line", 32'(line), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_strobes", 32'({pos_mono, neg_mono, red_mono}), 32'd0);
    check("rst_ready", 32'(req_ready), 32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    model_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset state with the driver enabled.
    step(1, 1, 0, 2'b00, 8'd0, 8'd0);

    // Rise with a hold of 3; ready returns 4 ticks after acceptance.
    step(1, 1, 1, 2'b01, 8'd3, 8'd2);
    repeat (4) step(1, 1, 0, 2'b00, 8'd0, 8'd0);

    // Fall with a hold of 2, then a redundant fall that keeps ready high.
    step(1, 1, 1, 2'b10, 8'd9, 8'd2);
    repeat (3) step(1, 1, 0, 2'b00, 8'd0, 8'd0);
    step(1, 1, 1, 2'b10, 8'd5, 8'd5);
    step(1, 1, 0, 2'b00, 8'd0, 8'd0);

    // Zero holds: a toggle on every tick.
    repeat (6) step(1, 1, 1, 2'b11, 8'd0, 8'd0);

    // clk_en low mid-hold freezes everything; the hold then resumes.
    step(1, 1, 1, 2'b01, 8'd6, 8'd6);
    step(1, 1, 1, 2'b01, 8'd6, 8'd6);
    step(1, 1, 1, 2'b10, 8'd6, 8'd6);
    repeat (5) step(0, 1, 1, 2'b10, 8'd1, 8'd1);
    repeat (8) step(1, 1, 0, 2'b00, 8'd0, 8'd0);

    // drive_en low mid-hold: the count continues, and ready stays low until drive_en returns.
    step(1, 1, 1, 2'b11, 8'd3, 8'd3);
    repeat (5) step(1, 0, 1, 2'b11, 8'd0, 8'd0);
    step(1, 1, 1, 2'b11, 8'd0, 8'd0);

    // Reset while holding high.
    step(1, 1, 1, 2'b10, 8'd0, 8'd0);
    step(1, 1, 1, 2'b01, 8'd5, 8'd5);
    step(1, 1, 0, 2'b00, 8'd0, 8'd0);
    reset_pulse();
    repeat (2) step(1, 1, 0, 2'b00, 8'd0, 8'd0);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      step(($urandom % 8) != 0, ($urandom % 6) != 0, ($urandom % 3) != 0,
           2'($urandom), 8'($urandom % 5), 8'($urandom % 5));
    end

`ifdef EDGE_DRIVER_FULL_STATS_EN
    // 65537 edges after reset must leave the counter at 1.
    reset_pulse();
    repeat (65537) step(1, 1, 1, 2'b11, 8'd0, 8'd0);
    check("edge_wrap", 32'(edge_count), 32'd1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
